dac_sample_delay: RTL and testbench

Parametrised sample-granular delay line for the DAC output path. It delays a stream of packed multi-sample DAC words by a programmable number of individual samples, from 0 up to NUM_STAGES full words. The block sits between the pulse/waveform generator and the RFSoC DAC interface. It adds three things to a plain word shifter:
- a registered, valid-qualified datapath;
- a handshaked shift-amount update that takes effect only on a word boundary;
- range checking and a history flush.

---
 rtl/dac_sample_delay_if.sv | 35 +++
 rtl/dac_sample_delay.sv | 123 ++++++++++++
 tb/tb_dac_sample_delay.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_sample_delay_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_delay_if
// Description : DAC sample stream and shift-configuration bundle for
//               dac_sample_delay.
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_sample_delay_if #(
    parameter int SAMPLE_W = 16,
    parameter int SPW      = 16,
    parameter int SHIFT_W  = 16
);
    logic [SAMPLE_W*SPW-1:0] dac_word_in;
    logic                    dac_valid_in;
    logic [SAMPLE_W*SPW-1:0] dac_word_out;
    logic                    dac_valid_out;
    logic [SHIFT_W-1:0]      cfg_shift;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [SHIFT_W-1:0]      shift_active;
    logic                    cfg_err;
    logic                    cfg_err_clr;
    logic                    flush;

    modport master (
        output dac_word_in, dac_valid_in, cfg_shift, cfg_valid, cfg_err_clr, flush,
        input  dac_word_out, dac_valid_out, cfg_ready, shift_active, cfg_err
    );

    modport slave (
        input  dac_word_in, dac_valid_in, cfg_shift, cfg_valid, cfg_err_clr, flush,
        output dac_word_out, dac_valid_out, cfg_ready, shift_active, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/dac_sample_delay.sv
`default_nettype none
// ============================================================================
// Module      : dac_sample_delay
// Description : Sample-granular delay line for packed DAC words with
//               word-boundary shift updates, range clamp and history flush.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_delay #(
    parameter int SAMPLE_W    = 16,
    parameter int SPW         = 16,
    parameter int NUM_STAGES  = 16,
    parameter int SHIFT_W     = 16,
    parameter int RESET_SHIFT = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dac_sample_delay_if.slave bus
);
    localparam int c_W         = SAMPLE_W * SPW;
    localparam int c_MAX_SHIFT = NUM_STAGES * SPW;
    localparam int c_WIN_W     = (NUM_STAGES + 1) * c_W;
    localparam int c_IDX_W     = $clog2(c_WIN_W);
    localparam logic [SHIFT_W-1:0] c_MAX   = SHIFT_W'(c_MAX_SHIFT);
    localparam logic [SHIFT_W-1:0] c_RESET = SHIFT_W'(RESET_SHIFT);

    // r_hist[0] is the most recent pushed word, r_hist[NUM_STAGES-1] the oldest
    logic [c_W-1:0]     r_hist [NUM_STAGES];
    logic [c_W-1:0]     r_word_out;
    logic               r_valid_out;
    logic [SHIFT_W-1:0] r_shift_active;
    logic [SHIFT_W-1:0] r_pend;
    logic               r_pend_valid;
    logic               r_cfg_err;

    logic               w_push;
    logic               w_accept;
    logic               w_over;
    logic [SHIFT_W-1:0] w_clamped;
    logic [SHIFT_W-1:0] w_shift_use;
    logic [SHIFT_W-1:0] w_sel;
    logic [c_IDX_W-1:0] w_bit_off;
    logic [c_WIN_W-1:0] w_window;
    logic [c_W-1:0]     w_selected;

    assign w_push    = bus.dac_valid_in && !bus.flush;
    assign w_accept  = bus.cfg_valid && !r_pend_valid;
    assign w_over    = bus.cfg_shift > c_MAX;
    assign w_clamped = w_over ? c_MAX : bus.cfg_shift;

    // A request accepted on a push cycle applies to that very push
    always_comb begin
        w_shift_use = r_shift_active;
        if (w_accept) begin
            w_shift_use = w_clamped;
        end else if (r_pend_valid) begin
            w_shift_use = r_pend;
        end
    end

    // Window is oldest sample in the LSBs up to the incoming word in the MSBs,
    // so a delay of s samples selects the word starting MAX_SHIFT-s samples in.
    always_comb begin
        w_window = '0;
        w_window[NUM_STAGES*c_W +: c_W] = bus.dac_word_in;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_window[(NUM_STAGES-1-i)*c_W +: c_W] = r_hist[i];
        end
    end

    assign w_sel      = c_MAX - w_shift_use;
    assign w_bit_off  = c_IDX_W'(32'(w_sel) * 32'(SAMPLE_W));
    assign w_selected = w_window[w_bit_off +: c_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_hist[i] <= '0;
            end
            r_word_out     <= '0;
            r_valid_out    <= 1'b0;
            r_shift_active <= c_RESET;
            r_pend         <= '0;
            r_pend_valid   <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_valid_out <= w_push;

            if (bus.flush) begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    r_hist[i] <= '0;
                end
            end else if (w_push) begin
                r_hist[0] <= bus.dac_word_in;
                for (int i = 1; i < NUM_STAGES; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end

            if (w_push) begin
                r_word_out     <= w_selected;
                r_shift_active <= w_shift_use;
                r_pend_valid   <= 1'b0;
            end else if (w_accept) begin
                r_pend       <= w_clamped;
                r_pend_valid <= 1'b1;
            end

            // A new range error takes priority over a simultaneous clear
            if (w_accept && w_over) begin
                r_cfg_err <= 1'b1;
            end else if (bus.cfg_err_clr) begin
                r_cfg_err <= 1'b0;
            end
        end
    end

    assign bus.dac_word_out  = r_word_out;
    assign bus.dac_valid_out = r_valid_out;
    assign bus.cfg_ready     = !r_pend_valid;
    assign bus.shift_active  = r_shift_active;
    assign bus.cfg_err       = r_cfg_err;
endmodule
`default_nettype wire

// File: tb/tb_dac_sample_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_sample_delay
// Description : Scoreboard testbench for dac_sample_delay (8-bit samples,
//               4 samples per word, 2 history stages).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_sample_delay;
    localparam int c_SAMPLE_W = 8;
    localparam int c_SPW      = 4;
    localparam int c_STAGES   = 2;
    localparam int c_SHIFT_W  = 8;
    localparam int c_RESET_SH = 0;
    localparam int c_MAX      = c_STAGES * c_SPW;

    logic clk;
    logic rst;

    dac_sample_delay_if #(.SAMPLE_W(c_SAMPLE_W), .SPW(c_SPW), .SHIFT_W(c_SHIFT_W)) bus ();

    dac_sample_delay #(
        .SAMPLE_W   (c_SAMPLE_W),
        .SPW        (c_SPW),
        .NUM_STAGES (c_STAGES),
        .SHIFT_W    (c_SHIFT_W),
        .RESET_SHIFT(c_RESET_SH)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model state
    int          m_stream[$];
    logic [31:0] m_expq[$];
    int          m_shift;
    int          m_pend;
    bit          m_pend_v;
    bit          m_err;
    logic [31:0] m_last_word;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkword(input int k);
        logic [31:0] w;
        for (int j = 0; j < c_SPW; j++) begin
            w[j*8 +: 8] = 8'((4*k + j) & 8'hFF);
        end
        return w;
    endfunction

    task automatic model_reset();
        m_stream.delete();
        m_expq.delete();
        m_shift     = c_RESET_SH;
        m_pend      = 0;
        m_pend_v    = 0;
        m_err       = 0;
        m_last_word = '0;
    endtask

    task automatic check_state(input string ph);
        chk({ph, "_cfg_ready"}, 64'(bus.cfg_ready), 64'(!m_pend_v));
        chk({ph, "_shift_active"}, 64'(bus.shift_active), 64'(m_shift));
        chk({ph, "_cfg_err"}, 64'(bus.cfg_err), 64'(m_err));
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge
    task automatic step(input bit v, input int k, input bit cv, input int cs,
                        input bit clr, input bit fl);
        logic [31:0] w;
        logic [31:0] e;
        bit          accept;
        bit          push;
        int          cl;
        int          use_s;
        int          base;
        int          n;
        w = mkword(k);
        bus.dac_word_in  = w;
        bus.dac_valid_in = v;
        bus.cfg_valid    = cv;
        bus.cfg_shift    = 8'(cs);
        bus.cfg_err_clr  = clr;
        bus.flush        = fl;

        accept = cv && !m_pend_v;
        push   = v && !fl;
        cl     = (cs > c_MAX) ? c_MAX : cs;
        if (accept && cs > c_MAX) m_err = 1;
        else if (clr)             m_err = 0;
        if (push) begin
            use_s = accept ? cl : (m_pend_v ? m_pend : m_shift);
            for (int j = 0; j < c_SPW; j++) m_stream.push_back((4*k + j) & 8'hFF);
            base = m_stream.size() - c_SPW;
            for (int j = 0; j < c_SPW; j++) begin
                n = base + j - use_s;
                e[j*8 +: 8] = (n >= 0) ? 8'(m_stream[n]) : 8'h00;
            end
            m_expq.push_back(e);
            m_last_word = e;
            m_shift     = use_s;
            m_pend_v    = 0;
        end else if (accept) begin
            m_pend   = cl;
            m_pend_v = 1;
        end
        if (fl) m_stream.delete();

        @(posedge clk);
        #1;
        chk("valid_out", 64'(bus.dac_valid_out), 64'(push));
        if (bus.dac_valid_out) begin
            chk("sb_nonempty", 64'(m_expq.size() > 0), 64'd1);
            if (m_expq.size() > 0) chk("word_out", 64'(bus.dac_word_out), 64'(m_expq.pop_front()));
        end else begin
            chk("word_hold", 64'(bus.dac_word_out), 64'(m_last_word));
        end
        check_state("step");
        bus.cfg_valid   = 1'b0;
        bus.cfg_err_clr = 1'b0;
        bus.flush       = 1'b0;
        bus.dac_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_word_out", 64'(bus.dac_word_out), 64'd0);
        chk("rst_valid_out", 64'(bus.dac_valid_out), 64'd0);
        check_state("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.dac_word_in  = '0;
        bus.dac_valid_in = 1'b0;
        bus.cfg_shift    = '0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_err_clr  = 1'b0;
        bus.flush        = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("init_word_out", 64'(bus.dac_word_out), 64'd0);
        chk("init_valid_out", 64'(bus.dac_valid_out), 64'd0);
        check_state("init");
        rst = 1'b0;

        // Pass-through with zero delay
        for (int k = 0; k < 4; k++) step(1, k, 0, 0, 0, 0);

        // Delay of 5 requested on the push of word 3
        do_reset();
        for (int k = 0; k < 3; k++) step(1, k, 0, 0, 0, 0);
        step(1, 3, 1, 5, 0, 0);
        chk("s5_k3_word", 64'(bus.dac_word_out), 64'h0A090807);
        step(1, 4, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0);
        // Accept on an idle cycle, then a second request while not ready is ignored
        step(0, 0, 1, 3, 0, 0);
        chk("pend_ready_low", 64'(bus.cfg_ready), 64'd0);
        step(0, 0, 1, 7, 0, 0);
        step(1, 6, 0, 0, 0, 0);

        // Maximum delay, then out-of-range request and set-beats-clear
        step(1, 7, 1, 8, 0, 0);
        step(1, 8, 0, 0, 0, 0);
        chk("s8_word_k_minus_2", 64'(bus.dac_word_out), 64'(mkword(6)));
        step(1, 9, 1, 9, 0, 0);
        chk("s9_clamped", 64'(bus.shift_active), 64'd8);
        step(1, 10, 1, 20, 1, 0);
        step(1, 11, 0, 0, 1, 0);

        // Stall between pushes with delay 3
        step(1, 12, 1, 3, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 13, 0, 0, 0, 0);
        step(1, 14, 0, 0, 0, 0);

        // Flush with delay 4
        do_reset();
        step(1, 0, 1, 4, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 1);
        step(1, 4, 0, 0, 0, 0);
        chk("flush_zero_word", 64'(bus.dac_word_out), 64'd0);
        // A request made during a flush survives it
        step(0, 0, 1, 2, 0, 1);
        step(1, 5, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0);

        // Reset with a request pending: pending value must never apply
        step(1, 7, 0, 0, 0, 0);
        step(0, 0, 1, 6, 0, 0);
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        chk("post_rst_passthru", 64'(bus.dac_word_out), 64'(mkword(0)));
        step(1, 1, 0, 0, 0, 0);

        chk("sb_drain", 64'(m_expq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
